mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/rv32im_pkg.sv | 44 ++++
 rtl/mdu_special.sv | 57 +++++
 rtl/mdu_ctrl.sv | 129 ++++++++++++
 tb/tb_mdu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32M definitions: funct3 codes, MDU op codes, controller FSM encoding.
package rv32im_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MULH = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_REM  = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } mdu_state_e;

  function automatic logic f3_executable(input logic [2:0] f3);
    return (f3 != F3_MULHSU) && (f3 != F3_MULHU);
  endfunction

  function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      F3_MULH: op = OP_MULH;
      F3_DIV:  op = OP_DIV;
      F3_DIVU: op = OP_DIVU;
      F3_REM:  op = OP_REM;
      F3_REMU: op = OP_REMU;
      default: op = OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_special.sv
// Combinational detection of divide-by-zero and signed-overflow cases,
// producing the architectural result so the MDU is never asked.
module mdu_special
  import rv32im_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_special,
  output logic [31:0] o_result
);

  logic w_zero;
  logic w_ovf;

  assign w_zero = (i_rs2 == 32'h0000_0000);
  assign w_ovf  = (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);

  always_comb begin
    o_special = 1'b0;
    o_result  = 32'h0000_0000;
    case (i_funct3)
      F3_DIV: begin
        if (w_zero) begin
          o_special = 1'b1;
          o_result  = 32'hFFFF_FFFF;
        end else if (w_ovf) begin
          o_special = 1'b1;
          o_result  = 32'h8000_0000;
        end
      end
      F3_DIVU: begin
        if (w_zero) begin
          o_special = 1'b1;
          o_result  = 32'hFFFF_FFFF;
        end
      end
      F3_REM: begin
        if (w_zero) begin
          o_special = 1'b1;
          o_result  = i_rs1;
        end else if (w_ovf) begin
          o_special = 1'b1;
          o_result  = 32'h0000_0000;
        end
      end
      F3_REMU: begin
        if (w_zero) begin
          o_special = 1'b1;
          o_result  = i_rs1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M execute-stage controller: resolves special cases locally (1 cycle),
// otherwise issues one MDU request and waits up to MAX_WAIT cycles for the answer.
module mdu_ctrl
  import rv32im_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ill,
  output logic        err,
  output logic        mdu_valid,
  output logic [2:0]  mdu_op,
  output logic [31:0] mdu_rs1,
  output logic [31:0] mdu_rs2,
  input  logic [31:0] mdu_result,
  input  logic        mdu_ready
);

  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  logic [2:0]  r_funct3;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic        r_err;
  logic        r_ill;
  logic [7:0]  r_cnt;

  logic        w_exec;
  logic        w_special;
  logic [31:0] w_special_res;
  logic        w_timeout;
  logic        w_busy;

  mdu_special u_special (
    .i_funct3  (ex_funct3),
    .i_rs1     (ex_rs1),
    .i_rs2     (ex_rs2),
    .o_special (w_special),
    .o_result  (w_special_res)
  );

  assign w_exec    = f3_executable(ex_funct3);
  assign w_timeout = (r_cnt == LP_LAST);
  assign w_busy    = (r_state == ST_REQ) || (r_state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (ex_valid && w_exec) w_state_nxt = w_special ? ST_WB : ST_REQ;
      ST_REQ:  w_state_nxt = ST_WAIT;
      ST_WAIT: if (mdu_ready || w_timeout) w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_ill    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_ill <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (ex_valid) begin
            r_funct3 <= ex_funct3;
            r_rs1    <= ex_rs1;
            r_rs2    <= ex_rs2;
            r_rd     <= ex_rd;
            r_result <= w_special_res;
            r_err    <= 1'b0;
            r_ill    <= !w_exec;
          end
        end
        ST_REQ: r_cnt <= '0;
        ST_WAIT: begin
          // A real answer wins even on the last allowed cycle.
          if (mdu_ready) begin
            r_result <= mdu_result;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall     = ((r_state == ST_IDLE) && ex_valid && w_exec) || w_busy;
  assign mdu_valid = (r_state == ST_REQ);
  assign mdu_op    = w_busy ? f3_to_op(r_funct3) : 3'b000;
  assign mdu_rs1   = w_busy ? r_rs1 : 32'h0;
  assign mdu_rs2   = w_busy ? r_rs2 : 32'h0;
  assign wb_valid  = (r_state == ST_WB);
  assign wb_rd     = wb_valid ? r_rd : 5'd0;
  assign wb_data   = wb_valid ? r_result : 32'h0;
  assign err       = wb_valid && r_err;
  assign ill       = r_ill;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MAX_WAIT = 15;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ill;
  logic        err;
  logic        mdu_valid;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_rs2;
  logic [31:0] mdu_result;
  logic        mdu_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_funct3  (ex_funct3),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .ex_rd      (ex_rd),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ill        (ill),
    .err        (err),
    .mdu_valid  (mdu_valid),
    .mdu_op     (mdu_op),
    .mdu_rs1    (mdu_rs1),
    .mdu_rs2    (mdu_rs2),
    .mdu_result (mdu_result),
    .mdu_ready  (mdu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Architectural RV32M result, including the defined divide corner cases.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q;
    logic               ovf;
    logic [31:0]        r;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'h0;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r = p[63:32];
      end
      3'd4: begin
        if (b == 0)   r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin q = $signed(a) / $signed(b); r = q; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0)   r = a;
        else if (ovf) r = 32'h0;
        else begin q = $signed(a) % $signed(b); r = q; end
      end
      3'd7: r = (b == 0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (f3[2] && b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && ovf);
  endfunction

  function automatic logic [2:0] exp_op(input logic [2:0] f3);
    logic [2:0] o;
    case (f3)
      3'd1: o = 3'd1;
      3'd4: o = 3'd2;
      3'd5: o = 3'd3;
      3'd6: o = 3'd4;
      3'd7: o = 3'd5;
      default: o = 3'd0;
    endcase
    return o;
  endfunction

  // External MDU: answers whatever operation code it was handed.
  function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [2:0] f3;
    case (op)
      3'd0: f3 = 3'd0;
      3'd1: f3 = 3'd1;
      3'd2: f3 = 3'd4;
      3'd3: f3 = 3'd5;
      3'd4: f3 = 3'd6;
      3'd5: f3 = 3'd7;
      default: f3 = 3'd2;
    endcase
    return (f3 == 3'd2) ? 32'hBAD0_0BAD : ref_result(f3, a, b);
  endfunction

  function automatic logic [31:0] pick_opnd();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 200));
      default: return $urandom;
    endcase
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_stall"},  32'(stall),     32'h0);
    chk({tag, "_wbv"},    32'(wb_valid),  32'h0);
    chk({tag, "_wbrd"},   32'(wb_rd),     32'h0);
    chk({tag, "_wbdat"},  wb_data,        32'h0);
    chk({tag, "_ill"},    32'(ill),       32'h0);
    chk({tag, "_err"},    32'(err),       32'h0);
    chk({tag, "_mvld"},   32'(mdu_valid), 32'h0);
    chk({tag, "_mop"},    32'(mdu_op),    32'h0);
    chk({tag, "_mrs1"},   mdu_rs1,        32'h0);
    chk({tag, "_mrs2"},   mdu_rs2,        32'h0);
  endtask

  // Call #1 after a rising edge with the DUT idle. dly = WAIT cycle (1-based)
  // in which the MDU answers; 0 or beyond MAX_WAIT means it never answers.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int dly, input bit noise);
    bit          exe, spec, tmo, nz;
    int          lat;
    logic [31:0] exp_res;
    logic [2:0]  op_seen;
    logic [31:0] a_seen, b_seen;
    exe  = (f3 != 3'b010) && (f3 != 3'b011);
    spec = exe && is_special(f3, a, b);
    tmo  = exe && !spec && (dly <= 0 || dly > MAX_WAIT);
    nz   = noise && exe;
    if (!exe || spec) lat = 1;
    else if (tmo)     lat = 2 + MAX_WAIT;
    else              lat = 2 + dly;
    exp_res = tmo ? 32'h0 : ref_result(f3, a, b);
    op_seen = 3'd0;
    a_seen  = 32'h0;
    b_seen  = 32'h0;
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    mdu_ready = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        ex_valid   = nz ? 1'($urandom_range(0, 1)) : 1'b0;
        ex_funct3  = 3'($urandom);
        ex_rs1     = $urandom;
        ex_rs2     = $urandom;
        ex_rd      = 5'($urandom);
        mdu_ready  = 1'b0;
        mdu_result = $urandom;
        if (exe && !spec) begin
          if (c == 1 && nz) mdu_ready = 1'($urandom_range(0, 1));
          else if (!tmo && c == 1 + dly) begin
            mdu_ready  = 1'b1;
            mdu_result = mdu_model(op_seen, a_seen, b_seen);
          end
        end
      end
      @(negedge clk);
      chk("stall", 32'(stall), 32'(exe && c < lat));
      chk("mdu_valid", 32'(mdu_valid), 32'(exe && !spec && c == 1));
      if (exe && !spec && c >= 1 && c < lat) begin
        if (c == 1) begin
          op_seen = mdu_op; a_seen = mdu_rs1; b_seen = mdu_rs2;
        end
        chk("mdu_op", 32'(mdu_op), 32'(exp_op(f3)));
        chk("mdu_rs1", mdu_rs1, a);
        chk("mdu_rs2", mdu_rs2, b);
      end
      chk("wb_valid", 32'(wb_valid), 32'(exe && c == lat));
      chk("ill", 32'(ill), 32'(!exe && c == 1));
      chk("err", 32'(err), 32'(tmo && c == lat));
      if (exe && c == lat) begin
        chk("wb_data", wb_data, exp_res);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
      end
      @(posedge clk);
      #1;
    end
    ex_valid  = 1'b0;
    mdu_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_funct3 = 3'd0; ex_rs1 = 32'h0; ex_rs2 = 32'h0;
    ex_rd = 5'd0; mdu_result = 32'h0; mdu_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(3'd5, 32'd100, 32'd7, 5'd3, 1, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1, 1'b0);
    run_op(3'd7, 32'd123, 32'd0, 5'd6, 1, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 5'd7, 1, 1'b0);
    run_op(3'd3, 32'd9, 32'd9, 5'd8, 1, 1'b0);
    run_op(3'd2, 32'd9, 32'd9, 5'd8, 1, 1'b0);
    run_op(3'd0, 32'd3, 32'd4, 5'd9, 0, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd10, MAX_WAIT, 1'b1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd0, MAX_WAIT - 1, 1'b1);

    // Reset while waiting on the MDU, then a late answer arrives.
    ex_valid = 1'b1; ex_funct3 = 3'd0; ex_rs1 = 32'd3; ex_rs2 = 32'd5; ex_rd = 5'd11;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("wait_stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; mdu_ready = 1'b1; mdu_result = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      all_zero("abort");
      @(posedge clk);
      #1;
    end
    mdu_ready = 1'b0;
    run_op(3'd0, 32'd6, 32'd7, 5'd12, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          d;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_opnd();
      b  = pick_opnd();
      d  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      run_op(f3, a, b, 5'($urandom), d, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
